rom_burst_loader: RTL

Parametrised successor to the single-word ROM loader: accepts a narrow input byte/beat stream, packs beats into ROM-width words, buffers them in a small FIFO, and writes a programmed number of words starting at a programmable base address through the ROM request/busy handshake. Sits between the external programming interface (e.g. SPI/UART receiver) and the ROM controller during boot loading; raises `done` when the image is complete.

---
 rtl/rom_loader_pkg.sv | 16 +
 rtl/rom_loader_fifo.sv | 56 +++++
 rtl/rom_burst_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared write-FSM encodings and width helpers for the ROM burst loader.
package rom_loader_pkg;
    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_BUSY
    } wstate_t;

    function automatic int calc_ratio(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

    function automatic bit widths_ok(input int data_width, input int in_width);
        return in_width > 0 && data_width >= in_width && data_width % in_width == 0;
    endfunction
endpackage

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo: synchronous FIFO of packed ROM words with registered full/empty flags.
module rom_loader_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_cnt_next;

    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && !r_empty;
    assign w_cnt_next = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_data     = r_mem[r_rd];
    assign o_full     = r_full;
    assign o_empty    = r_empty;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_cnt   <= w_cnt_next;
            r_full  <= w_cnt_next == (AW+1)'(DEPTH);
            r_empty <= w_cnt_next == '0;
        end
    end
endmodule

// File: rtl/rom_burst_loader.sv
// rom_burst_loader: packs narrow input beats into ROM words, buffers them and
// burst-writes a programmed word count from a base address via request/busy.
module rom_burst_loader
    import rom_loader_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int MSB_FIRST     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base_address,
    input  logic [ADDRESS_WIDTH:0]   i_word_count,
    input  logic                     i_in_valid,
    input  logic [IN_WIDTH-1:0]      i_in_data,
    output logic                     o_in_ready,
    input  logic                     i_rom_busy,
    input  logic                     i_rom_initialized,
    output logic                     o_rom_request,
    output logic [DATA_WIDTH-1:0]    o_rom_data,
    output logic [ADDRESS_WIDTH-1:0] o_rom_address,
    output logic                     o_loading,
    output logic                     o_word_ack,
    output logic                     o_done
);
    localparam int RATIO = calc_ratio(DATA_WIDTH, IN_WIDTH);
    localparam int BW    = RATIO > 1 ? $clog2(RATIO) : 1;

    if (!widths_ok(DATA_WIDTH, IN_WIDTH)) begin : g_width_check
        $error("rom_burst_loader: DATA_WIDTH must be an integer multiple of IN_WIDTH");
    end

    wstate_t                  r_state;
    logic [BW-1:0]            r_beat;
    logic [DATA_WIDTH-1:0]    r_pack;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [ADDRESS_WIDTH:0]   r_count;
    logic [ADDRESS_WIDTH:0]   r_accepted;
    logic [ADDRESS_WIDTH:0]   r_written;
    logic                     r_request;
    logic                     r_loading;
    logic                     r_ack;
    logic                     r_done;
    logic [DATA_WIDTH-1:0]    w_pack_next;
    logic [DATA_WIDTH-1:0]    w_fifo_data;
    logic [ADDRESS_WIDTH:0]   w_written_next;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_fire;
    logic                     w_last;
    logic                     w_push;
    logic                     w_pop;

    assign o_in_ready     = r_loading && !w_full && r_accepted != r_count;
    assign w_fire         = i_in_valid && o_in_ready;
    assign w_last         = r_beat == BW'(RATIO - 1);
    assign w_push         = w_fire && w_last;
    assign w_pop          = r_state == W_IDLE && !w_empty && i_rom_initialized && !i_rom_busy;
    assign w_written_next = r_written + (ADDRESS_WIDTH+1)'(1);
    // The final beat's word goes straight from the shifter into the FIFO.
    assign w_pack_next    = (MSB_FIRST != 0)
        ? (r_pack << IN_WIDTH) | DATA_WIDTH'(i_in_data)
        : (r_pack >> IN_WIDTH) | (DATA_WIDTH'(i_in_data) << (DATA_WIDTH - IN_WIDTH));

    assign o_rom_request = r_request;
    assign o_rom_data    = r_data;
    assign o_rom_address = r_address;
    assign o_loading     = r_loading;
    assign o_word_ack    = r_ack;
    assign o_done        = r_done;

    rom_loader_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_data (w_pack_next),
        .i_pop  (w_pop),
        .o_data (w_fifo_data),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= W_IDLE;
            r_beat     <= '0;
            r_pack     <= '0;
            r_data     <= '0;
            r_address  <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_request  <= 1'b0;
            r_loading  <= 1'b0;
            r_ack      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            if (i_start && !r_loading) begin
                r_address  <= i_base_address;
                r_count    <= i_word_count;
                r_accepted <= '0;
                r_written  <= '0;
                r_beat     <= '0;
                r_pack     <= '0;
                r_loading  <= i_word_count != '0;
                r_done     <= i_word_count == '0;
            end
            if (w_fire) begin
                r_pack <= w_pack_next;
                r_beat <= w_last ? '0 : r_beat + BW'(1);
                if (w_last)
                    r_accepted <= r_accepted + (ADDRESS_WIDTH+1)'(1);
            end
            case (r_state)
                W_IDLE: if (w_pop) begin
                    r_data    <= w_fifo_data;
                    r_request <= 1'b1;
                    r_state   <= W_REQ;
                end
                W_REQ: if (i_rom_busy) begin
                    r_request <= 1'b0;
                    r_state   <= W_BUSY;
                end
                W_BUSY: if (!i_rom_busy) begin
                    r_ack     <= 1'b1;
                    r_address <= r_address + ADDRESS_WIDTH'(1);
                    r_written <= w_written_next;
                    r_state   <= W_IDLE;
                    if (w_written_next == r_count) begin
                        r_done    <= 1'b1;
                        r_loading <= 1'b0;
                    end
                end
                default: r_state <= W_IDLE;
            endcase
        end
    end
endmodule
